// File: rtl/clock_enable_sequencer_if.sv
// Bundles the lock, pacing-control and enable signals that pass between the
// PLL/board side and the clock enable sequencer.
interface clock_enable_sequencer_if;
    logic       pll_locked;
    logic       pause;
    logic [1:0] turbo;
    logic       core_reset_n;
    logic       ce_32k;
    logic       ce_256;

    // Board/PLL side: supplies lock and pacing controls, consumes the enables.
    modport master (
        output pll_locked,
        output pause,
        output turbo,
        input  core_reset_n,
        input  ce_32k,
        input  ce_256
    );

    // Sequencer side.
    modport slave (
        input  pll_locked,
        input  pause,
        input  turbo,
        output core_reset_n,
        output ce_32k,
        output ce_256
    );
endinterface

// File: rtl/clock_enable_sequencer.sv
// Qualifies PLL lock, holds the core in reset until the clock has been stable
// for LOCK_HOLD cycles, then paces the core with single-cycle enables:
// ce_32k every `period` cycles (shortened by turbo) and ce_256 on every 128th
// ce_32k. All outputs come straight from flops.
module clock_enable_sequencer #(
    parameter int DIVIDE      = 400,
    parameter int LOCK_HOLD   = 1024,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    clock_enable_sequencer_if.slave  bus
);

    localparam int DIV_W  = $clog2(DIVIDE);
    localparam int PER_W  = $clog2(DIVIDE + 1);
    localparam int HOLD_W = $clog2(LOCK_HOLD + 1);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LOCK_HOLD - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        RUN       = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   locked_s;

    state_t                 state_reg, state_next;
    logic [HOLD_W-1:0]      hold_reg, hold_next;
    logic [DIV_W-1:0]       div_cnt_reg, div_cnt_next;
    logic [PER_W-1:0]       period_reg, period_next;
    logic [6:0]             sub_cnt_reg, sub_cnt_next;
    logic                   core_reset_n_reg, core_reset_n_next;
    logic                   ce_32k_reg, ce_32k_next;
    logic                   ce_256_reg, ce_256_next;

    logic                   run, run_next, entering, advance, wrap;
    logic [PER_W-1:0]       period_load;

    assign locked_s = sync_reg[SYNC_STAGES-1];

    // Bring the asynchronous PLL lock flag into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], bus.pll_locked};
        end
    end

    // Lock qualification: any loss of lock restarts the full hold interval.
    always_comb begin
        state_next = state_reg;
        hold_next  = hold_reg;
        case (state_reg)
            WAIT_LOCK: begin
                if (locked_s) begin
                    hold_next  = '0;
                    state_next = STABILIZE;
                end
            end
            STABILIZE: begin
                if (!locked_s) begin
                    state_next = WAIT_LOCK;
                end else if (hold_reg == HOLD_LAST) begin
                    state_next = RUN;
                end else begin
                    hold_next = hold_reg + HOLD_W'(1);
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_next = WAIT_LOCK;
                end
            end
            default: state_next = WAIT_LOCK;
        endcase
    end

    // Divider, period reload and enable look-ahead. The enables are computed
    // one cycle early from next-state values so that the flopped ce_32k is
    // high exactly in the cycle where div_cnt sits at period-1.
    always_comb begin
        run         = (state_reg == RUN);
        run_next    = (state_next == RUN);
        entering    = run_next && !run;
        advance     = run && run_next && !bus.pause;
        wrap        = advance && (PER_W'(div_cnt_reg) == period_reg - PER_W'(1));
        period_load = PER_W'(DIVIDE >> bus.turbo);

        period_next = period_reg;
        if (entering || wrap) begin
            period_next = period_load;
        end

        div_cnt_next = div_cnt_reg;
        if (!run_next) begin
            div_cnt_next = '0;
        end else if (advance) begin
            div_cnt_next = wrap ? '0 : div_cnt_reg + DIV_W'(1);
        end

        ce_32k_next = run_next && (entering || advance) &&
                      (PER_W'(div_cnt_next) == period_next - PER_W'(1));
        ce_256_next = ce_32k_next && (sub_cnt_reg == 7'd127);

        sub_cnt_next = sub_cnt_reg;
        if (!run_next) begin
            sub_cnt_next = '0;
        end else if (ce_32k_next) begin
            sub_cnt_next = sub_cnt_reg + 7'd1;
        end

        core_reset_n_next = run_next;
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= WAIT_LOCK;
            hold_reg         <= '0;
            div_cnt_reg      <= '0;
            period_reg       <= PER_W'(DIVIDE);
            sub_cnt_reg      <= '0;
            core_reset_n_reg <= 1'b0;
            ce_32k_reg       <= 1'b0;
            ce_256_reg       <= 1'b0;
        end else begin
            state_reg        <= state_next;
            hold_reg         <= hold_next;
            div_cnt_reg      <= div_cnt_next;
            period_reg       <= period_next;
            sub_cnt_reg      <= sub_cnt_next;
            core_reset_n_reg <= core_reset_n_next;
            ce_32k_reg       <= ce_32k_next;
            ce_256_reg       <= ce_256_next;
        end
    end

    assign bus.core_reset_n = core_reset_n_reg;
    assign bus.ce_32k       = ce_32k_reg;
    assign bus.ce_256       = ce_256_reg;

endmodule
